mycpu_fu: RTL and testbench
===========================

Name: mycpu_fu

Overview:
- Registered 16-function ALU/shifter (function unit) of the mycpu datapath.
- Each cycle it consumes operands A and B plus a 4-bit function select, and registers the result with zero and negative status flags.
- Result feeds the register-file write-back mux; flags feed branch logic.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits; all arithmetic is modulo 2^DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, synchronous, active-high
- a_in  input  DATA_WIDTH  operand A
- b_in  input  DATA_WIDTH  operand B
- fs_in  input  4  function select
- f_out  output  DATA_WIDTH  registered result
- z_out  output  1  registered zero flag
- n_out  output  1  registered negative flag

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, f_out=0, z_out=1, n_out=0.
- Reset takes priority over any fs_in and operands in the same cycle.
- Latency is 1 cycle. Inputs sampled at edge k appear on f_out/z_out/n_out after edge k. There is no handshake; a new operation is accepted every cycle.
- Function map for F, computed combinationally and then registered:
  - 0000: A
  - 0001: A+1
  - 0010: A+B
  - 0011: A+B+1
  - 0100: A+~B
  - 0101: A+~B+1 (A−B)
  - 0110: A−1
  - 0111: A
  - 1000: A&B
  - 1001: A|B
  - 1010: A^B
  - 1011: ~A
  - 1100: B
  - 1101: B>>1, logical, MSB filled with 0
  - 1110: B<<1, LSB filled with 0
  - 1111: 0
- Arithmetic wraps silently. Examples: 0xFFFF+1=0x0000; 0x0000−1=0xFFFF; 0x8000−1=0x7FFF.
- z_out = (F == 0); n_out = F[DATA_WIDTH−1]. Both are registered in the same edge as f_out, so they are always consistent with f_out.
- Shifts operate on B only; A is ignored for 1100–1110. Codes 0000/0111/1011 ignore B.
- Outputs hold their value only if inputs hold; there is no enable. Each non-reset edge unconditionally loads a new result.
- X/unknown on fs_in is not a supported stimulus. Out-of-range values do not exist, since all 16 codes are defined.

Optional Feature:
- Macro FU_CARRY_FLAGS_EN.
- When defined, two extra registered outputs are added after n_out:
  - c_out (1 bit): carry-out of the adder for codes 0001–0110. For 1101 it is the bit shifted out (B[0]); for 1110 it is B[MSB]. It is 0 for all other codes.
  - v_out (1 bit): two's-complement signed overflow for codes 0001–0110, otherwise 0.
  - Both reset to 0 and follow the same 1-cycle latency.
- When undefined, the ports and logic are absent and the port list is exactly as above.

Test Plan:
- Reset: rst=1 for 2 edges with a_in=0x1234, b_in=0x5678, fs=0010 -> f_out=0x0000, z=1, n=0. Release rst -> next edge f_out=0x68AC, z=0, n=0.
- Add/sub wrap: A=0xFFFF, fs=0001 -> f=0x0000, z=1, n=0. A=0x0005, B=0x0007, fs=0101 -> f=0xFFFE, n=1, z=0. A=0x0000, fs=0110 -> f=0xFFFF, n=1.
- Logic: A=0xF0F0, B=0x0FF0 with fs=1000 -> 0x00F0; fs=1001 -> 0xFFF0; fs=1010 -> 0xFF00; fs=1011 -> 0x0F0F.
- Shifts/transfer: B=0x8001 with fs=1101 -> 0x4000; fs=1110 -> 0x0002; fs=1100 -> 0x8001, n=1. fs=1111 -> 0x0000, z=1.
- Back-to-back latency: change fs every cycle through all 16 codes with A=0x0003, B=0x0002. Each result appears exactly one edge after its inputs: 0003, 0004, 0005, 0006, 0000, 0001, 0002, 0003, 0002, 0003, 0001, FFFC, 0002, 0001, 0004, 0000.
- Mid-stream reset: assert rst for one edge during the back-to-back sequence -> that edge yields f=0, z=1, n=0. The next edge resumes the correct result for the current inputs. With FU_CARRY_FLAGS_EN defined, additionally check A=0x7FFF, B=0x0001, fs=0010 -> f=0x8000, v=1, c=0.

Source files
------------

// File: rtl/mycpu_fu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mycpu_fu                                                      |
// | Purpose  : Registered 16-function ALU/shifter with zero/negative flags.  |
// |            Define FU_CARRY_FLAGS_EN to add registered c_out/v_out.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mycpu_fu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [3:0]            fs_in,
  output logic [DATA_WIDTH-1:0] f_out,
  output logic                  z_out,
  output logic                  n_out
`ifdef FU_CARRY_FLAGS_EN
  ,
  output logic                  c_out,
  output logic                  v_out
`endif
);

  localparam logic [3:0] c_FS_PASS_A  = 4'b0000;
  localparam logic [3:0] c_FS_INC_A   = 4'b0001;
  localparam logic [3:0] c_FS_ADD     = 4'b0010;
  localparam logic [3:0] c_FS_ADD_C   = 4'b0011;
  localparam logic [3:0] c_FS_ADD_NB  = 4'b0100;
  localparam logic [3:0] c_FS_SUB     = 4'b0101;
  localparam logic [3:0] c_FS_DEC_A   = 4'b0110;
  localparam logic [3:0] c_FS_PASS_A2 = 4'b0111;
  localparam logic [3:0] c_FS_AND     = 4'b1000;
  localparam logic [3:0] c_FS_OR      = 4'b1001;
  localparam logic [3:0] c_FS_XOR     = 4'b1010;
  localparam logic [3:0] c_FS_NOT_A   = 4'b1011;
  localparam logic [3:0] c_FS_PASS_B  = 4'b1100;
  localparam logic [3:0] c_FS_SHR_B   = 4'b1101;
  localparam logic [3:0] c_FS_SHL_B   = 4'b1110;
  localparam logic [3:0] c_FS_ZERO    = 4'b1111;

  // All six arithmetic codes share one adder: F = A + w_add_b + w_cin.
  logic [DATA_WIDTH-1:0] w_add_b;
  logic                  w_cin;
  logic [DATA_WIDTH-1:0] w_f;
  logic                  w_z;
  logic                  w_n;

  always_comb begin
    w_add_b = '0;
    w_cin   = 1'b0;
    case (fs_in)
      c_FS_INC_A:  begin w_add_b = '0;     w_cin = 1'b1; end
      c_FS_ADD:    begin w_add_b = b_in;   w_cin = 1'b0; end
      c_FS_ADD_C:  begin w_add_b = b_in;   w_cin = 1'b1; end
      c_FS_ADD_NB: begin w_add_b = ~b_in;  w_cin = 1'b0; end
      c_FS_SUB:    begin w_add_b = ~b_in;  w_cin = 1'b1; end
      c_FS_DEC_A:  begin w_add_b = '1;     w_cin = 1'b0; end
      default:     begin w_add_b = '0;     w_cin = 1'b0; end
    endcase
  end

`ifdef FU_CARRY_FLAGS_EN
  logic [DATA_WIDTH:0] w_sum;
  logic                w_is_arith;
  logic                w_c;
  logic                w_v;

  assign w_sum = {1'b0, a_in} + {1'b0, w_add_b} + {{DATA_WIDTH{1'b0}}, w_cin};
  assign w_is_arith = (fs_in >= c_FS_INC_A) && (fs_in <= c_FS_DEC_A);

  always_comb begin
    w_c = 1'b0;
    w_v = 1'b0;
    if (w_is_arith) begin
      w_c = w_sum[DATA_WIDTH];
      // Overflow: like-signed operands produce a result of the other sign.
      w_v = (a_in[DATA_WIDTH-1] == w_add_b[DATA_WIDTH-1]) &&
            (w_sum[DATA_WIDTH-1] != a_in[DATA_WIDTH-1]);
    end else if (fs_in == c_FS_SHR_B) begin
      w_c = b_in[0];
    end else if (fs_in == c_FS_SHL_B) begin
      w_c = b_in[DATA_WIDTH-1];
    end
  end
`else
  logic [DATA_WIDTH-1:0] w_sum;

  assign w_sum = a_in + w_add_b + {{(DATA_WIDTH-1){1'b0}}, w_cin};
`endif

  always_comb begin
    w_f = '0;
    case (fs_in)
      c_FS_PASS_A, c_FS_PASS_A2: w_f = a_in;
      c_FS_INC_A, c_FS_ADD, c_FS_ADD_C,
      c_FS_ADD_NB, c_FS_SUB, c_FS_DEC_A: w_f = w_sum[DATA_WIDTH-1:0];
      c_FS_AND:    w_f = a_in & b_in;
      c_FS_OR:     w_f = a_in | b_in;
      c_FS_XOR:    w_f = a_in ^ b_in;
      c_FS_NOT_A:  w_f = ~a_in;
      c_FS_PASS_B: w_f = b_in;
      c_FS_SHR_B:  w_f = {1'b0, b_in[DATA_WIDTH-1:1]};
      c_FS_SHL_B:  w_f = {b_in[DATA_WIDTH-2:0], 1'b0};
      c_FS_ZERO:   w_f = '0;
      default:     w_f = '0;
    endcase
  end

  assign w_z = (w_f == '0);
  assign w_n = w_f[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      f_out <= '0;
      z_out <= 1'b1;
      n_out <= 1'b0;
    end else begin
      f_out <= w_f;
      z_out <= w_z;
      n_out <= w_n;
    end
  end

`ifdef FU_CARRY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      c_out <= 1'b0;
      v_out <= 1'b0;
    end else begin
      c_out <= w_c;
      v_out <= w_v;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mycpu_fu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mycpu_fu                                                   |
// | Purpose  : Directed self-checking bench for mycpu_fu.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mycpu_fu;

  logic        clk;
  logic        rst;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  fs_in;
  logic [15:0] f_out;
  logic        z_out;
  logic        n_out;
`ifdef FU_CARRY_FLAGS_EN
  logic        c_out;
  logic        v_out;
`endif

  int errors = 0;
  int checks = 0;

  mycpu_fu #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_in  (a_in),
    .b_in  (b_in),
    .fs_in (fs_in),
    .f_out (f_out),
    .z_out (z_out),
    .n_out (n_out)
`ifdef FU_CARRY_FLAGS_EN
    ,
    .c_out (c_out),
    .v_out (v_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] fs);
    rst   = r;
    a_in  = a;
    b_in  = b;
    fs_in = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] ef, input logic ez,
                       input logic en);
    checks++;
    assert ({f_out, z_out, n_out} === {ef, ez, en}) else begin
      errors++;
      $error("FAIL %s: got f=%h z=%b n=%b, expected f=%h z=%b n=%b",
             tag, f_out, z_out, n_out, ef, ez, en);
    end
  endtask

`ifdef FU_CARRY_FLAGS_EN
  task automatic check_cv(input string tag, input logic ec, input logic ev);
    checks++;
    assert ({c_out, v_out} === {ec, ev}) else begin
      errors++;
      $error("FAIL %s: got c=%b v=%b, expected c=%b v=%b", tag, c_out, v_out, ec, ev);
    end
  endtask
`endif

  logic [15:0] exp_b2b [16];

  initial begin
    exp_b2b = '{16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0000, 16'h0001,
                16'h0002, 16'h0003, 16'h0002, 16'h0003, 16'h0001, 16'hFFFC,
                16'h0002, 16'h0001, 16'h0004, 16'h0000};
    rst = 1'b1; a_in = '0; b_in = '0; fs_in = '0;
    #2;

    // Reset wins over a pending ADD.
    step(1'b1, 16'h1234, 16'h5678, 4'b0010);
    check("reset_edge1", 16'h0000, 1'b1, 1'b0);
`ifdef FU_CARRY_FLAGS_EN
    check_cv("reset_cv", 1'b0, 1'b0);
`endif
    step(1'b1, 16'h1234, 16'h5678, 4'b0010);
    check("reset_edge2", 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h1234, 16'h5678, 4'b0010);
    check("add_after_reset", 16'h68AC, 1'b0, 1'b0);

    // Wrap-around arithmetic.
    step(1'b0, 16'hFFFF, 16'h0000, 4'b0001);
    check("inc_wrap", 16'h0000, 1'b1, 1'b0);
`ifdef FU_CARRY_FLAGS_EN
    check_cv("inc_wrap_cv", 1'b1, 1'b0);
`endif
    step(1'b0, 16'h0005, 16'h0007, 4'b0101);
    check("sub_neg", 16'hFFFE, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h1234, 4'b0110);
    check("dec_wrap", 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 16'h8000, 16'h0000, 4'b0110);
    check("dec_8000", 16'h7FFF, 1'b0, 1'b0);

    // Logic functions.
    step(1'b0, 16'hF0F0, 16'h0FF0, 4'b1000);
    check("and", 16'h00F0, 1'b0, 1'b0);
    step(1'b0, 16'hF0F0, 16'h0FF0, 4'b1001);
    check("or", 16'hFFF0, 1'b0, 1'b1);
    step(1'b0, 16'hF0F0, 16'h0FF0, 4'b1010);
    check("xor", 16'hFF00, 1'b0, 1'b1);
    step(1'b0, 16'hF0F0, 16'h0FF0, 4'b1011);
    check("not_a", 16'h0F0F, 1'b0, 1'b0);

    // Shifts and transfers act on B only.
    step(1'b0, 16'hAAAA, 16'h8001, 4'b1101);
    check("shr_b", 16'h4000, 1'b0, 1'b0);
`ifdef FU_CARRY_FLAGS_EN
    check_cv("shr_cv", 1'b1, 1'b0);
`endif
    step(1'b0, 16'hAAAA, 16'h8001, 4'b1110);
    check("shl_b", 16'h0002, 1'b0, 1'b0);
`ifdef FU_CARRY_FLAGS_EN
    check_cv("shl_cv", 1'b1, 1'b0);
`endif
    step(1'b0, 16'hAAAA, 16'h8001, 4'b1100);
    check("pass_b", 16'h8001, 1'b0, 1'b1);
    step(1'b0, 16'hAAAA, 16'h8001, 4'b1111);
    check("zero", 16'h0000, 1'b1, 1'b0);

    // Back-to-back sweep of all codes with a one-edge reset after code 7.
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        step(1'b1, 16'h0003, 16'h0002, 4'(i));
        check("midstream_reset", 16'h0000, 1'b1, 1'b0);
      end
      step(1'b0, 16'h0003, 16'h0002, 4'(i));
      check($sformatf("b2b_fs%0d", i), exp_b2b[i], exp_b2b[i] == 16'h0000,
            exp_b2b[i][15]);
    end

`ifdef FU_CARRY_FLAGS_EN
    step(1'b0, 16'h7FFF, 16'h0001, 4'b0010);
    check("ovf_add", 16'h8000, 1'b0, 1'b1);
    check_cv("ovf_add_cv", 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
